aes_ct_buffer: RTL and testbench
================================

AES_CT_BUFFER -- requirements
Module: aes_ct_buffer

Interface
REQ-001 Parameter Nk, default 4: key words of the upstream encryptor (4/6/8); informational only, no effect on buffering.
REQ-002 Parameter DEPTH, default 16: ciphertext entries held; power of two, 2..256.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_b  input  1  reset, synchronous, active-low.
REQ-005 load  input  1  copy of the load pulse issued to the encryptor; one pulse = one block in flight.
REQ-006 ct_valid  input  1  ciphertext valid from encryptor, no backpressure.
REQ-007 ct  input  128  ciphertext block, sampled when ct_valid=1.
REQ-008 load_ok  output  1  credit: upstream may assert load this cycle.
REQ-009 out_valid  output  1  head entry available.
REQ-010 out_ready  input  1  downstream accepts head entry.
REQ-011 out_ct  output  128  head ciphertext block.
REQ-012 level  output  $clog2(DEPTH)+1  entries stored (excludes in-flight).
REQ-013 err  output  1  sticky protocol-violation flag.

Function
REQ-014 Reserved counter, range 0..DEPTH: +1 on load, -1 on out_valid&out_ready; both in one cycle -> unchanged.
REQ-015 load_ok SHALL equal (reserved < DEPTH), combinational from registered state only (no path from load or out_ready).
REQ-016 load while load_ok=0 SHALL set err; reserved saturates at DEPTH; the block is still counted by ct_valid handling.
REQ-017 ct_valid=1 SHALL write ct at write pointer when level<DEPTH, or when level=DEPTH and a pop occurs the same cycle.
REQ-018 ct_valid=1 with level=DEPTH and no pop SHALL drop ct and set err; stored data unchanged.
REQ-019 Write-to-output latency: out_valid=1 and out_ct=written block on the cycle after the ct_valid cycle (1 clk).
REQ-020 Empty FIFO with ct_valid SHALL NOT bypass combinationally to out_ct.
REQ-021 out_valid = (level != 0); out_ct held stable while out_valid=1 and out_ready=0.
REQ-022 Pop on out_valid&out_ready; out_ready with out_valid=0 ignored, no state change, no err.
REQ-023 Simultaneous push and pop: level unchanged, both pointers advance, order preserved.
REQ-024 Pointers $clog2(DEPTH) bits, wrap from DEPTH-1 to 0; strict FIFO order.
REQ-025 ct_valid without a prior matching load (reserved=0, level=0) SHALL still store the block and set err.
REQ-026 err clears only on reset.

Reset
REQ-027 rst_b=0 at a rising edge: reserved=0, level=0, pointers=0, err=0; outputs then load_ok=1, out_valid=0, out_ct=0.
REQ-028 Storage array not reset; out_ct SHALL read 0 whenever out_valid=0.
REQ-029 Reset mid-operation discards stored and in-flight blocks; a ct_valid in the first cycle after reset release is accepted as new data and sets err (REQ-025).

Structure
REQ-030 DEPTH default and the 128-bit block width as shared constants in aes_pkg, together with the aes_block_t typedef.
REQ-031 One sub-module aes_sync_fifo (storage, pointers, level); credit and err logic in the top.

Verification
REQ-032 Reset, then 1 load, ct_valid with ct=0x3925841d02dc09fbdc118597196a0b32 2 cycles later, out_ready=1 -> out_valid 1 cycle after ct_valid with that value, level 1->0, load_ok stays 1.
REQ-033 DEPTH=16, out_ready=0, 16 loads -> load_ok=0 after 16th; 16 ct_valid -> level=16; 17th load -> err=1.
REQ-034 Full FIFO, ct_valid and out_ready same cycle -> level stays 16, head advances, err stays 0.
REQ-035 Back-to-back 40 blocks with out_ready toggling 50% -> output order and values identical to input, no err, load_ok never allows reserved>16.
REQ-036 Reset asserted with level=5 -> next cycle level=0, out_valid=0, load_ok=1, err=0.
REQ-037 ct_valid with no prior load -> block stored, err=1 next cycle.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and types for the AES ciphertext buffering path.
package aes_pkg;

   localparam int AES_BLOCK_W    = 128;
   localparam int AES_FIFO_DEPTH = 16;

   typedef logic [AES_BLOCK_W-1:0] aes_block_t;

   // True when v is a power of two in the range the buffer supports.
   function automatic bit aes_depth_ok(input int v);
      return (v >= 2) && (v <= 256) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/aes_sync_fifo.sv
// Ciphertext storage: single-clock FIFO with wrapping pointers and an
// occupancy count. The caller only pushes when not full (or when popping in
// the same cycle) and only pops when not empty. Reads are from registered
// state, so a pushed block becomes visible the cycle after the push.
module aes_sync_fifo
   import aes_pkg::*;
#(
   parameter int DEPTH = AES_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_b,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [AES_BLOCK_W-1:0]   wdata_i,
   output logic [AES_BLOCK_W-1:0]   rdata_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   aes_block_t    mem_q [DEPTH];

   // Next pointer / occupancy; power-of-two depth lets the pointers wrap naturally.
   always_comb begin
      wr_ptr_d = push_i ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop_i  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      level_d  = level_q;
      case ({push_i, pop_i})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array write; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   // Force zero when empty so stale, unreset storage never leaks out.
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
   assign level_o = level_q;

endmodule

// File: rtl/aes_ct_buffer.sv
// Ciphertext buffer behind an AES encryptor that has no backpressure.
// Upstream may only issue a load while a credit is available; the credit
// count (reserved) covers blocks in flight plus blocks stored, so every
// issued block is guaranteed a slot when its ciphertext arrives.
module aes_ct_buffer
   import aes_pkg::*;
#(
   parameter int Nk    = 4,
   parameter int DEPTH = AES_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_b,
   input  logic                     load,
   input  logic                     ct_valid,
   input  logic [AES_BLOCK_W-1:0]   ct,
   output logic                     load_ok,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [AES_BLOCK_W-1:0]   out_ct,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     err
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam logic [LW-1:0] DEPTH_C = LW'(DEPTH);

   // Elaboration guards: key size is informational, depth must be a power of two.
   if (!aes_depth_ok(DEPTH)) begin : g_bad_depth
      $error("aes_ct_buffer: DEPTH must be a power of two in 2..256");
   end
   if (!((Nk == 4) || (Nk == 6) || (Nk == 8))) begin : g_bad_nk
      $error("aes_ct_buffer: Nk must be 4, 6 or 8");
   end

   logic [LW-1:0] reserved_q, reserved_d;
   logic          err_q, err_d;
   logic          fifo_full, fifo_empty;
   logic          push, pop;
   logic [LW-1:0] fifo_level;

   // Head pops only when something is there; a write into a full FIFO is
   // allowed only when the head leaves in the same cycle.
   assign pop  = !fifo_empty && out_ready;
   assign push = ct_valid && (!fifo_full || pop);

   aes_sync_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_b   (rst_b),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (ct),
      .rdata_o (out_ct),
      .level_o (fifo_level),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Credit from registered state only, so no path from load/out_ready.
   assign load_ok   = (reserved_q < DEPTH_C);
   assign out_valid = !fifo_empty;
   assign level     = fifo_level;
   assign err       = err_q;

   // Credit and sticky-error next state.
   always_comb begin
      reserved_d = reserved_q;
      case ({load, pop})
         2'b10:   reserved_d = (reserved_q == DEPTH_C) ? reserved_q : reserved_q + LW'(1);
         2'b01:   reserved_d = (reserved_q == '0)      ? reserved_q : reserved_q - LW'(1);
         default: reserved_d = reserved_q;
      endcase

      err_d = err_q;
      // Load issued without credit.
      if (load && !load_ok) err_d = 1'b1;
      // Ciphertext arrives into a full FIFO with nothing leaving: dropped.
      if (ct_valid && fifo_full && !pop) err_d = 1'b1;
      // Ciphertext with no outstanding load at all; it is still stored.
      if (ct_valid && (reserved_q == '0) && fifo_empty) err_d = 1'b1;
   end

   // Control registers with synchronous active-low reset; err is sticky.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         reserved_q <= '0;
         err_q      <= 1'b0;
      end else begin
         reserved_q <= reserved_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_aes_ct_buffer.sv
// Self-checking bench for aes_ct_buffer: queue-based reference model,
// per-cycle output comparison, and directed scenarios with literal checks.
module tb_aes_ct_buffer;

   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_b;
   logic          load;
   logic          ct_valid;
   logic [127:0]  ct;
   logic          load_ok;
   logic          out_valid;
   logic          out_ready;
   logic [127:0]  out_ct;
   logic [LW-1:0] level;
   logic          err;

   aes_ct_buffer #(.Nk(4), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .load      (load),
      .ct_valid  (ct_valid),
      .ct        (ct),
      .load_ok   (load_ok),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ct    (out_ct),
      .level     (level),
      .err       (err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_on = 0;

   // Reference model: a queue of stored blocks, a credit count, a sticky error.
   logic [127:0] mq[$];
   int           mres = 0;
   bit           merr = 0;
   int           popcnt = 0;
   int           msz;
   bit           mpop;

   always @(posedge clk) begin
      if (!rst_b) begin
         mq.delete();
         mres = 0;
         merr = 0;
      end else begin
         msz  = mq.size();
         mpop = (msz != 0) && out_ready;
         if (load && !(mres < DEPTH)) merr = 1;
         if (ct_valid && msz == 0 && mres == 0) merr = 1;
         if (mpop) begin
            void'(mq.pop_front());
            popcnt++;
         end
         if (ct_valid) begin
            if (msz < DEPTH || mpop) mq.push_back(ct);
            else merr = 1;
         end
         if (load && !mpop) mres = (mres < DEPTH) ? mres + 1 : mres;
         else if (mpop && !load) mres = (mres > 0) ? mres - 1 : 0;
      end
   end

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", nm, got, exp);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("m_level",     128'(level),     128'(mq.size()));
         chk("m_out_valid", 128'(out_valid), 128'(mq.size() != 0));
         chk("m_out_ct",    out_ct,          (mq.size() != 0) ? mq[0] : 128'h0);
         chk("m_load_ok",   128'(load_ok),   128'(mres < DEPTH));
         chk("m_err",       128'(err),       128'(merr));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic idle();
      load = 0; ct_valid = 0; out_ready = 0; ct = '0;
   endtask

   task automatic do_reset();
      idle();
      rst_b = 0;
      tick();
      rst_b = 1;
   endtask

   task automatic drain();
      out_ready = 1;
      for (int i = 0; i < DEPTH + 2; i++) tick();
      out_ready = 0;
   endtask

   logic [127:0] blk [DEPTH];
   int           due[$];
   int           loaded;
   int           base;
   int           cyc;

   initial begin
      idle();
      rst_b = 0;
      tick();
      tick();
      chk_on = 1;
      // Reset state.
      chk("rst_load_ok",   128'(load_ok),   128'd1);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_out_ct",    out_ct,          128'h0);
      chk("rst_level",     128'(level),     128'd0);
      chk("rst_err",       128'(err),       128'd0);
      rst_b = 1;
      tick();

      // Single block through the buffer.
      load = 1; tick(); load = 0;
      tick();
      ct_valid = 1; ct = 128'h3925841d02dc09fbdc118597196a0b32; out_ready = 1;
      tick();
      ct_valid = 0;
      chk("one_out_valid", 128'(out_valid), 128'd1);
      chk("one_out_ct",    out_ct,          128'h3925841d02dc09fbdc118597196a0b32);
      chk("one_level1",    128'(level),     128'd1);
      chk("one_load_ok1",  128'(load_ok),   128'd1);
      tick();
      chk("one_level0",    128'(level),     128'd0);
      chk("one_load_ok2",  128'(load_ok),   128'd1);
      chk("one_err",       128'(err),       128'd0);
      out_ready = 0;

      // Fill credits and storage, then overrun credit.
      for (int i = 0; i < DEPTH; i++) begin load = 1; tick(); end
      load = 0;
      chk("fill_load_ok", 128'(load_ok), 128'd0);
      for (int i = 0; i < DEPTH; i++) begin
         blk[i] = rnd128(); ct_valid = 1; ct = blk[i]; tick();
      end
      ct_valid = 0;
      chk("fill_level", 128'(level), 128'd16);
      chk("fill_err0",  128'(err),   128'd0);
      chk("fill_head",  out_ct,      blk[0]);
      load = 1; tick(); load = 0;
      chk("fill_err1",  128'(err),   128'd1);
      drain();
      do_reset();

      // Full FIFO: write and pop in the same cycle.
      for (int i = 0; i < DEPTH; i++) begin load = 1; tick(); end
      load = 0;
      for (int i = 0; i < DEPTH; i++) begin
         blk[i] = rnd128(); ct_valid = 1; ct = blk[i]; tick();
      end
      ct_valid = 1; ct = rnd128(); out_ready = 1;
      tick();
      ct_valid = 0; out_ready = 0;
      chk("full_pp_level", 128'(level), 128'd16);
      chk("full_pp_head",  out_ct,      blk[1]);
      chk("full_pp_err",   128'(err),   128'd0);
      // Full FIFO, no pop: block dropped, head unchanged.
      ct_valid = 1; ct = rnd128(); tick(); ct_valid = 0;
      chk("full_drop_level", 128'(level), 128'd16);
      chk("full_drop_head",  out_ct,      blk[1]);
      chk("full_drop_err",   128'(err),   128'd1);
      drain();
      do_reset();

      // Reset with five blocks stored.
      for (int i = 0; i < 5; i++) begin
         load = 1; ct_valid = (i > 0); ct = rnd128(); tick();
      end
      load = 0; ct_valid = 1; ct = rnd128(); tick(); ct_valid = 0;
      chk("mid_level5", 128'(level), 128'd5);
      rst_b = 0; tick();
      chk("mid_rst_level",     128'(level),     128'd0);
      chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
      chk("mid_rst_load_ok",   128'(load_ok),   128'd1);
      chk("mid_rst_err",       128'(err),       128'd0);
      chk("mid_rst_out_ct",    out_ct,          128'h0);
      rst_b = 1;

      // Ciphertext with no prior load, first cycle after reset release.
      ct_valid = 1; ct = 128'h00112233445566778899aabbccddeeff; tick(); ct_valid = 0;
      chk("noload_level", 128'(level), 128'd1);
      chk("noload_ct",    out_ct,      128'h00112233445566778899aabbccddeeff);
      chk("noload_err",   128'(err),   128'd1);
      do_reset();

      // Streaming: 40 blocks, random latency, out_ready toggling.
      loaded = 0; base = popcnt; cyc = 0; due.delete();
      while ((popcnt - base) < 40 && cyc < 3000) begin
         out_ready = $urandom_range(0, 1);
         load = (loaded < 40) && (mres < DEPTH) && ($urandom_range(0, 3) != 0);
         ct_valid = 0;
         if (due.size() != 0 && due[0] <= cyc) begin
            void'(due.pop_front());
            ct_valid = 1;
            ct = rnd128();
         end
         if (load) begin
            loaded++;
            due.push_back(cyc + 1 + $urandom_range(0, 2));
         end
         tick();
         cyc++;
      end
      idle();
      chk("stream_done", 128'(popcnt - base), 128'd40);
      chk("stream_err",  128'(err),           128'd0);

      // Unconstrained random traffic including protocol violations and resets.
      for (int i = 0; i < 400; i++) begin
         rst_b     = ($urandom_range(0, 60) != 0);
         load      = ($urandom_range(0, 3) == 0);
         ct_valid  = ($urandom_range(0, 2) == 0);
         ct        = rnd128();
         out_ready = $urandom_range(0, 1);
         tick();
      end
      idle();
      rst_b = 1;
      tick();

      chk_on = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
